dice_roll_sequencer: RTL and testbench

Synchronous controller that turns a raw push-button press into one complete, animated dice roll. It debounces the button, runs an 11-bit LFSR dice generator through a slowing series of steps so the displayed face visibly tumbles, then freezes the face and flags it valid. It sits between the board button/mode switch and the D4..D8 face outputs. It replaces the button-clocked generator with a single-clock design.

---
 rtl/dice_pkg.sv | 37 +++
 rtl/dice_roll_sequencer_debounce.sv | 60 ++++++
 rtl/dice_roll_sequencer.sv | 134 +++++++++++++
 tb/tb_dice_roll_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared constants, state encoding and face-mapping helpers for the dice roll
// sequencer and its debounce front end.
package dice_pkg;

  localparam int LFSR_W = 11;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 11'd18;
  localparam int TAP_HI = 10;
  localparam int TAP_LO = 1;

  localparam logic [4:0] FACE_D6  = 5'd6;
  localparam logic [4:0] FACE_D20 = 5'd20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

  // Face is taken from the low LFSR bits of the state before it advances.
  function automatic logic [4:0] map_face(input logic [LFSR_W-1:0] lfsr, input logic mode);
    logic [4:0] raw;
    logic [4:0] face;
    if (mode) begin
      raw  = lfsr[4:0];
      face = (raw % FACE_D20) + 5'd1;
    end else begin
      raw  = {2'b00, lfsr[2:0]};
      face = (raw % FACE_D6) + 5'd1;
    end
    return face;
  endfunction

endpackage

// File: rtl/dice_roll_sequencer_debounce.sv
// Button front end: two-flop synchronizer, stable-level debounce counter and a
// registered one-cycle pulse on each rising edge of the debounced level.
module dice_debounce
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger_i,
  output logic start_o
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            level_q;
  logic            level_d;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;
  logic            start_q;
  logic            start_d;

  // Debounce decision: the level flips on the sample that completes the run.
  always_comb begin
    level_d = level_q;
    cnt_d   = {DB_W{1'b0}};
    start_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = ~level_q;
        cnt_d   = {DB_W{1'b0}};
        start_d = ~level_q;
      end else begin
        cnt_d   = cnt_q + DB_W'(1);
      end
    end else begin
      cnt_d = {DB_W{1'b0}};
    end
  end

  // Synchronizer, debounce state and start pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= {DB_W{1'b0}};
      start_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], trigger_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  assign start_o = start_q;

endmodule

// File: rtl/dice_roll_sequencer.sv
// Dice roll sequencer: a debounced press starts a tumble of LFSR-derived faces
// with growing gaps between steps, then freezes the face and pulses valid.
module dice_roll_sequencer
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ROLL_STEPS      = 8,
  parameter int STEP_BASE       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic       twty_mode,
  output logic [4:0] value,
  output logic       busy,
  output logic       valid,
  output logic       mode_q
);

  localparam int STEP_MAX = STEP_BASE * ROLL_STEPS;
  localparam int CNT_W    = $clog2(STEP_MAX + 1);
  localparam logic [3:0] LAST_IDX = 4'(ROLL_STEPS - 1);

  state_e            state_q;
  state_e            state_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic [4:0]        value_q;
  logic [4:0]        value_d;
  logic              busy_q;
  logic              busy_d;
  logic              valid_q;
  logic              valid_d;
  logic              mode_reg_q;
  logic              mode_reg_d;
  logic [3:0]        idx_q;
  logic [3:0]        idx_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  term_s;
  logic              start_s;

  dice_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk      (clk),
    .rst      (rst),
    .trigger_i(trigger),
    .start_o  (start_s)
  );

  // Gap before step idx is STEP_BASE*(idx+1) cycles, so the counter ends one below.
  assign term_s = CNT_W'(STEP_BASE * (int'(idx_q) + 32'sd1) - 32'sd1);

  // Next-state logic; busy and valid are computed for the following cycle.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    value_d    = value_q;
    mode_reg_d = mode_reg_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    busy_d     = 1'b0;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        lfsr_d = lfsr_next(lfsr_q);
        if (start_s) begin
          state_d    = ROLL;
          mode_reg_d = twty_mode;
          idx_d      = 4'd0;
          cnt_d      = {CNT_W{1'b0}};
          busy_d     = 1'b1;
        end else begin
          busy_d     = 1'b0;
        end
      end
      ROLL: begin
        busy_d = 1'b1;
        if (cnt_q == term_s) begin
          value_d = map_face(lfsr_q, mode_reg_q);
          lfsr_d  = lfsr_next(lfsr_q);
          idx_d   = idx_q + 4'd1;
          cnt_d   = {CNT_W{1'b0}};
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            valid_d = 1'b1;
          end else begin
            state_d = ROLL;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_SEED;
      value_q    <= 5'd0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      mode_reg_q <= 1'b0;
      idx_q      <= 4'd0;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      value_q    <= value_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      mode_reg_q <= mode_reg_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
    end
  end

  assign value  = value_q;
  assign busy   = busy_q;
  assign valid  = valid_q;
  assign mode_q = mode_reg_q;

endmodule

// File: tb/tb_dice_roll_sequencer.sv
// Scoreboard bench for dice_roll_sequencer: a behavioural model schedules the
// expected faces and valid pulse per roll; a negedge monitor consumes them.
module tb_dice_roll_sequencer;

  localparam int DB = 16;
  localparam int RS = 8;
  localparam int SB = 4;
  localparam int PRESS_TO_BUSY = DB + 3;
  localparam int ROLL_LEN      = SB * RS * (RS + 1) / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       trigger;
  logic       twty_mode;
  logic [4:0] value;
  logic       busy;
  logic       valid;
  logic       mode_q;

  dice_roll_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .ROLL_STEPS     (RS),
    .STEP_BASE      (SB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .trigger  (trigger),
    .twty_mode(twty_mode),
    .value    (value),
    .busy     (busy),
    .valid    (valid),
    .mode_q   (mode_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [4:0] face;
    logic       mode;
  } ev_t;

  ev_t step_q[$];
  ev_t valid_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // reference model state
  logic [10:0] m_lfsr = 11'd18;
  bit          m_active = 1'b0;
  int          m_end = -10;
  bit          m_mode = 1'b0;
  bit          m_start_pend = 1'b0;
  bit          m_s0 = 1'b0, m_s1 = 1'b0, m_level = 1'b0;
  int          m_cnt = 0;
  int          m_epoch = 0;

  int          seen_epoch = 0;
  logic [4:0]  exp_value = 5'd0;

  function automatic logic [10:0] adv(input logic [10:0] s);
    return {s[9:0], s[10] ^ s[1]};
  endfunction

  function automatic logic [4:0] face_of(input logic [10:0] s, input bit d20);
    int x;
    int v;
    x = int'(s);
    if (d20) v = (x % 32) % 20 + 1;
    else     v = (x % 8) % 6 + 1;
    return 5'(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s cyc=%0d actual=timeout expected=event", name, cyc);
  endtask

  task automatic model_step();
    logic [10:0] s;
    int          t;
    logic [4:0]  f;
    cyc++;
    if (rst) begin
      m_lfsr = 11'd18; m_active = 1'b0; m_end = -10; m_mode = 1'b0;
      m_start_pend = 1'b0; m_s0 = 1'b0; m_s1 = 1'b0; m_level = 1'b0; m_cnt = 0;
      step_q.delete();
      valid_q.delete();
      m_epoch++;
      return;
    end
    if (m_active && cyc == m_end + 1) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_lfsr = adv(m_lfsr);
      if (m_start_pend) begin
        m_mode   = twty_mode;
        m_active = 1'b1;
        s = m_lfsr;
        t = cyc;
        f = 5'd0;
        for (int i = 0; i < RS; i++) begin
          t += SB * (i + 1);
          f = face_of(s, m_mode);
          step_q.push_back('{t, f, m_mode});
          s = adv(s);
        end
        m_end  = t;
        m_lfsr = s;
        valid_q.push_back('{t, f, m_mode});
      end
    end
    m_start_pend = 1'b0;
    if (m_s1 != m_level) begin
      m_cnt++;
      if (m_cnt == DB) begin
        m_level      = !m_level;
        m_cnt        = 0;
        m_start_pend = m_level;
      end
    end else begin
      m_cnt = 0;
    end
    m_s1 = m_s0;
    m_s0 = trigger;
  endtask

  task automatic monitor_step();
    ev_t ev;
    if (m_epoch != seen_epoch) begin
      seen_epoch = m_epoch;
      exp_value  = 5'd0;
    end
    while (step_q.size() > 0 && step_q[0].t == cyc) begin
      ev = step_q.pop_front();
      exp_value = ev.face;
      if (ev.mode) chk("d20_range", int'(value >= 5'd1 && value <= 5'd20), 1);
      else chk("d6_range", int'(value >= 5'd1 && value <= 5'd6 && value[4:3] == 2'd0), 1);
    end
    chk("value", value, exp_value);
    chk("busy", busy, m_active);
    chk("valid", valid, int'(m_active && cyc == m_end));
    chk("mode_q", mode_q, m_mode);
    if (!m_active) chk("lfsr", dut.lfsr_q, m_lfsr);
    if (valid) begin
      chk("valid_pending", int'(valid_q.size() > 0), 1);
      if (valid_q.size() > 0) begin
        ev = valid_q.pop_front();
        chk("valid_time", cyc, ev.t);
        chk("valid_face", value, ev.face);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  task automatic wait_busy(input string name, input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (busy) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) timeout_fail(name);
  endtask

  task automatic wait_valid(input string name, input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) timeout_fail(name);
  endtask

  int rise, at_b, at_v, nvalid, late_busy, busy_seen;

  initial begin
    rst = 1'b1; trigger = 1'b0; twty_mode = 1'b0;
    @(negedge clk);
    chk("rst_value", value, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_lfsr", dut.lfsr_q, 18);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // clean d6 press held for 200 cycles
    twty_mode = 1'b0; rise = cyc; trigger = 1'b1;
    wait_busy("d6_busy_wait", 60, at_b);
    chk("d6_press_to_busy", at_b - rise, PRESS_TO_BUSY);
    wait_valid("d6_valid_wait", 200, at_v);
    chk("d6_press_to_valid", at_v - rise, PRESS_TO_BUSY + ROLL_LEN);
    nvalid = 0;
    while (cyc - rise < 200) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    chk("d6_extra_valid", nvalid, 0);
    trigger = 1'b0;
    repeat (40) @(negedge clk);

    // d20 roll with mode dropped after step 2
    twty_mode = 1'b1; trigger = 1'b1;
    wait_busy("d20_busy_wait", 60, at_b);
    repeat (SB + 2 * SB + 2) @(negedge clk);
    twty_mode = 1'b0;
    wait_valid("d20_valid_wait", 200, at_v);
    chk("d20_mode_q", mode_q, 1);
    trigger = 1'b0;
    repeat (40) @(negedge clk);

    // bounce: 5-cycle pulses never settle long enough
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      trigger = 1'b1;
      repeat (5) begin @(negedge clk); busy_seen |= int'(busy); end
      trigger = 1'b0;
      repeat (5) begin @(negedge clk); busy_seen |= int'(busy); end
    end
    repeat (40) begin @(negedge clk); busy_seen |= int'(busy); end
    chk("bounce_busy", busy_seen, 0);

    // release and re-press during the roll
    twty_mode = 1'b0; trigger = 1'b1;
    wait_busy("retrig_busy_wait", 60, at_b);
    repeat (40) @(negedge clk);
    trigger = 1'b0;
    repeat (30) @(negedge clk);
    trigger = 1'b1;
    nvalid = 0; late_busy = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (valid) nvalid++;
      if (i >= 150) late_busy |= int'(busy);
    end
    chk("retrig_single_valid", nvalid, 1);
    chk("retrig_no_restart", late_busy, 0);
    trigger = 1'b0;
    repeat (40) @(negedge clk);
    rise = cyc; trigger = 1'b1;
    wait_busy("retrig_fresh_wait", 60, at_b);
    chk("retrig_fresh_latency", at_b - rise, PRESS_TO_BUSY);
    wait_valid("retrig_fresh_valid", 200, at_v);
    trigger = 1'b0;
    repeat (40) @(negedge clk);

    // reset right after step 5
    twty_mode = 1'b1; trigger = 1'b1;
    wait_busy("midrst_busy_wait", 60, at_b);
    repeat (SB * 15) @(negedge clk);
    rst = 1'b1; trigger = 1'b0;
    @(negedge clk);
    chk("midrst_value", value, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_mode_q", mode_q, 0);
    chk("midrst_lfsr", dut.lfsr_q, 18);
    rst = 1'b0;
    nvalid = 0;
    repeat (200) begin @(negedge clk); if (valid) nvalid++; end
    chk("midrst_no_valid", nvalid, 0);

    // randomized rolls with random idle gaps for LFSR entropy
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 50)) @(negedge clk);
      twty_mode = 1'($urandom_range(0, 1));
      trigger = 1'b1;
      repeat ($urandom_range(170, 260)) begin
        @(negedge clk);
        if ($urandom_range(0, 9) == 0) twty_mode = ~twty_mode;
      end
      trigger = 1'b0;
      repeat (40) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("queues_drained", step_q.size() + valid_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
